ring_counter_param: RTL and testbench

//  Parametrised one-hot ring / Johnson (twisted-ring) sequencer for phase and slot selection.

---
 rtl/ring_pkg.sv | 73 +++++++
 rtl/ring_counter_param_decode.sv | 41 ++++
 rtl/ring_counter_param.sv | 133 +++++++++++++
 tb/tb_ring_counter_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and pattern helpers for the ring / Johnson sequencer.
// The helpers work on a fixed MAX_W-bit vector plus a run-time width, so any
// WIDTH up to MAX_W can use them. Callers zero-extend and slice at the edges.
package ring_pkg;

   typedef enum logic {RING = 1'b0, JOHNSON = 1'b1} ring_mode_e;

   localparam int MAX_W = 32;

   typedef logic [MAX_W-1:0] pat_t;

   // Ones in bits [w-1:0], zeros above.
   function automatic pat_t width_mask(int w);
      pat_t m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Ring starts with only the MSB set, Johnson starts at all zeros.
   function automatic pat_t start_pat(ring_mode_e mode, int w);
      pat_t p;
      p = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (mode == RING && i == w - 1) p[i] = 1'b1;
      end
      return p;
   endfunction

   // Ring: exactly one bit set. Johnson: at most one 0/1 boundary between
   // neighbouring bits, i.e. a thermometer filled from the MSB or the LSB.
   function automatic logic is_legal(ring_mode_e mode, pat_t pat, int w);
      int ones;
      int edges;
      ones  = 0;
      edges = 0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w && pat[i]) ones++;
      end
      for (int i = 0; i < MAX_W - 1; i++) begin
         if (i < w - 1 && pat[i] != pat[i+1]) edges++;
      end
      if (mode == RING) return (ones == 1);
      return (edges <= 1);
   endfunction

   // One step: dir=0 shifts toward the LSB, dir=1 toward the MSB. The bit that
   // falls off re-enters at the other end, inverted in Johnson mode.
   function automatic pat_t next_pat(ring_mode_e mode, logic dir, pat_t pat, int w);
      pat_t r;
      logic msb;
      logic fill;
      msb = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i == w - 1) msb = pat[i];
      end
      if (!dir) begin
         fill = (mode == RING) ? pat[0] : ~pat[0];
         r    = (pat & width_mask(w)) >> 1;
         for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) r[i] = fill;
         end
      end else begin
         fill = (mode == RING) ? msb : ~msb;
         r    = (pat << 1) & width_mask(w);
         r[0] = fill;
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_counter_param_decode.sv
// Combinational decode of a pattern into {legal, position in its sequence}.
// Position is only meaningful when legal is set.
module ring_decode
   import ring_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] pat,
   input  ring_mode_e       mode,
   output logic             legal,
   output logic [IDX_W-1:0] idx
);

   pat_t wide;
   int   ones;
   int   pos;

   // Ring index counts from the MSB; Johnson index is the step count from zero,
   // which is the ones count while filling, then 2*WIDTH - ones while draining.
   always_comb begin
      wide             = '0;
      wide[WIDTH-1:0]  = pat;
      legal            = is_legal(mode, wide, WIDTH);
      ones             = 0;
      pos              = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pat[i]) begin
            ones++;
            pos = WIDTH - 1 - i;
         end
      end
      if (mode == RING)
         idx = IDX_W'(pos);
      else if (pat[WIDTH-1] || ones == 0)
         idx = IDX_W'(ones);
      else
         idx = IDX_W'(2*WIDTH - ones);
   end

endmodule

// File: rtl/ring_counter_param.sv
// One-hot ring / Johnson sequencer with load, direction, mode switch and
// illegal-state recovery. All outputs are registered; idx tracks q.
module ring_counter_param
   import ring_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [IDX_W-1:0] idx,
   output logic             wrap,
   output logic             err
);

   localparam logic [IDX_W-1:0] RING_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] JOHN_LAST = IDX_W'(2*WIDTH - 1);
   localparam logic [WIDTH-1:0] RING_START = WIDTH'(1) << (WIDTH - 1);

   ring_mode_e       mode_in;
   ring_mode_e       mode_q, mode_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic             q_legal, ld_legal;
   logic [IDX_W-1:0] q_pos, ld_pos;
   logic [WIDTH-1:0] q_step, start_cur, start_new;
   logic [IDX_W-1:0] idx_step, seq_last;

   // Narrow wrappers around the package helpers.
   function automatic logic [WIDTH-1:0] step_pat(ring_mode_e m, logic d, logic [WIDTH-1:0] p);
      pat_t w;
      w              = '0;
      w[WIDTH-1:0]   = p;
      w              = next_pat(m, d, w, WIDTH);
      return w[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] start_of(ring_mode_e m);
      pat_t w;
      w = start_pat(m, WIDTH);
      return w[WIDTH-1:0];
   endfunction

   assign mode_in = ring_mode_e'(mode);

   // Decode the current state (in the registered mode) and the load candidate.
   ring_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec_q (
      .pat   (q_q),
      .mode  (mode_q),
      .legal (q_legal),
      .idx   (q_pos)
   );

   ring_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec_ld (
      .pat   (load_val),
      .mode  (mode_q),
      .legal (ld_legal),
      .idx   (ld_pos)
   );

   // Step candidate: next pattern and its index, wrapping modulo sequence length.
   always_comb begin
      start_cur = start_of(mode_q);
      start_new = start_of(mode_in);
      q_step    = step_pat(mode_q, dir, q_q);
      seq_last  = (mode_q == RING) ? RING_LAST : JOHN_LAST;
      if (!dir)
         idx_step = (q_pos == seq_last) ? '0 : q_pos + 1'b1;
      else
         idx_step = (q_pos == '0) ? seq_last : q_pos - 1'b1;
   end

   // Priority mux: mode change > load > illegal-state fix > step > hold.
   always_comb begin
      mode_d = mode_q;
      q_d    = q_q;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (mode_in != mode_q) begin
         mode_d = mode_in;
         q_d    = start_new;
         idx_d  = '0;
      end else if (load) begin
         if (ld_legal) begin
            q_d   = load_val;
            idx_d = ld_pos;
         end else begin
            err_d = 1'b1;
         end
      end else if (!q_legal) begin
         q_d   = start_cur;
         idx_d = '0;
         err_d = 1'b1;
      end else if (en) begin
         q_d    = q_step;
         idx_d  = idx_step;
         wrap_d = (q_step == start_cur);
      end
   end

   // State and output registers, async reset to the ring start pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= RING;
         q_q    <= RING_START;
         idx_q  <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         q_q    <= q_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign q    = q_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;
   assign err  = err_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param at WIDTH=4: a vector table run through a
// one-deep scoreboard, plus hand sequences for reset, upset and async reset.
module tb_ring_counter_param;

   localparam int WIDTH = 4;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             en, dir, mode, load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [IDX_W-1:0] idx;
   logic             wrap, err;

   // ctl = {mode, en, dir, load}; fl = {wrap, err}
   typedef struct {
      logic [3:0]       ctl;
      logic [WIDTH-1:0] lv;
      logic [WIDTH-1:0] eq;
      logic [IDX_W-1:0] ei;
      logic [1:0]       fl;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   ring_counter_param #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .idx      (idx),
      .wrap     (wrap),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [3:0] ctl, logic [3:0] lv, logic [3:0] eq,
                               logic [2:0] ei, logic [1:0] fl);
      vec_t v;
      v.ctl = ctl; v.lv = lv; v.eq = eq; v.ei = ei; v.fl = fl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, ".q"},    32'(q),    32'(e.eq));
      chk({tag, ".idx"},  32'(idx),  32'(e.ei));
      chk({tag, ".wrap"}, 32'(wrap), 32'(e.fl[1]));
      chk({tag, ".err"},  32'(err),  32'(e.fl[0]));
   endtask

   // Drive on the falling edge, expect the result just after the next rising edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      {mode, en, dir, load} = v.ctl;
      load_val              = v.lv;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk_all(tag, e);
      end
   endtask

   initial begin
      vec_t rv;

      // ctl = {mode,en,dir,load}, load_val, exp q, exp idx, {wrap,err}
      // ring stepping right from reset
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b0100, 3'd1, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b0010, 3'd2, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b0001, 3'd3, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b1000, 3'd0, 2'b10));
      // switch to Johnson, then full cycle
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b1000, 3'd1, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b1100, 3'd2, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b1110, 3'd3, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b1111, 3'd4, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0111, 3'd5, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0011, 3'd6, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0001, 3'd7, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0000, 3'd0, 2'b10));
      // reverse from start, then forward back into start
      vecs.push_back(mk(4'b1110, 4'b0000, 4'b0001, 3'd7, 2'b00));
      vecs.push_back(mk(4'b1100, 4'b0000, 4'b0000, 3'd0, 2'b10));
      // Johnson loads: legal, illegal, load beats en, start pattern
      vecs.push_back(mk(4'b1001, 4'b1100, 4'b1100, 3'd2, 2'b00));
      vecs.push_back(mk(4'b1001, 4'b0101, 4'b1100, 3'd2, 2'b01));
      vecs.push_back(mk(4'b1101, 4'b1111, 4'b1111, 3'd4, 2'b00));
      vecs.push_back(mk(4'b1001, 4'b0000, 4'b0000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b1110, 4'b0000, 4'b0001, 3'd7, 2'b00));
      vecs.push_back(mk(4'b1110, 4'b0000, 4'b0011, 3'd6, 2'b00));
      // back to ring: mode change ignores en
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b1000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b0001, 4'b0010, 4'b0010, 3'd2, 2'b00));
      vecs.push_back(mk(4'b0110, 4'b0000, 4'b0100, 3'd1, 2'b00));
      vecs.push_back(mk(4'b0110, 4'b0000, 4'b1000, 3'd0, 2'b10));
      vecs.push_back(mk(4'b0110, 4'b0000, 4'b0001, 3'd3, 2'b00));
      // ring loads: illegal rejected, legal accepted, start load has no wrap
      vecs.push_back(mk(4'b0001, 4'b0110, 4'b0001, 3'd3, 2'b01));
      vecs.push_back(mk(4'b0001, 4'b0010, 4'b0010, 3'd2, 2'b00));
      vecs.push_back(mk(4'b0001, 4'b0000, 4'b0010, 3'd2, 2'b01));
      vecs.push_back(mk(4'b0001, 4'b1000, 4'b1000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b1000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b0110, 4'b0000, 4'b0001, 3'd3, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b1000, 3'd0, 2'b10));
      // mode change beats load
      vecs.push_back(mk(4'b1001, 4'b0001, 4'b0000, 3'd0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b1000, 3'd0, 2'b00));

      // reset state
      rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
      repeat (2) @(posedge clk);
      #1;
      rv = mk(4'b0000, 4'b0000, 4'b1000, 3'd0, 2'b00);
      chk_all("reset", rv);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

      // upset: q forced illegal with en=1 -> corrected to start, no step
      @(negedge clk);
      {mode, en, dir, load} = 4'b0100;
      force dut.q_q = 4'b1010;
      @(posedge clk);
      #1;
      chk("upset.err",  32'(err),  32'd1);
      chk("upset.idx",  32'(idx),  32'd0);
      chk("upset.wrap", 32'(wrap), 32'd0);
      release dut.q_q;
      apply(mk(4'b0001, 4'b0100, 4'b0100, 3'd1, 2'b00), "post_upset");
      apply(mk(4'b0100, 4'b0000, 4'b0010, 3'd2, 2'b00), "pre_rst");

      // async reset between edges takes effect without a clock
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      rv = mk(4'b0000, 4'b0000, 4'b1000, 3'd0, 2'b00);
      chk_all("async_rst", rv);
      @(negedge clk);
      rst = 1'b0;
      // load and en together: load wins
      apply(mk(4'b0101, 4'b0010, 4'b0010, 3'd2, 2'b00), "load_en");
      apply(mk(4'b0100, 4'b0000, 4'b0001, 3'd3, 2'b00), "after_load");
      apply(mk(4'b0100, 4'b0000, 4'b1000, 3'd0, 2'b10), "wrap_again");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
